// File: rtl/mips_pkg.sv
// Shared constants and control payload for the MIPS pipeline controller.
// Holds opcode/funct encodings, 3-bit ALU codes, the decoded-control struct
// and the R-type funct -> ALU code mapping.
package mips_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALU_W     = 3;
    localparam int unsigned MDU_CNT_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;

    localparam logic [FUNCT_W-1:0] FN_ADD   = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB   = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND   = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR    = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT   = 6'h2A;
    localparam logic [FUNCT_W-1:0] FN_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FN_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FN_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'h1B;
    localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'h12;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic              regwrite;
        logic              regdst;
        logic              alusrc;
        logic              memtoreg;
        logic              memwrite;
        logic              memen;
        logic              branch;
        logic              jump;
        logic              mdu_op;   // mult/multu/div/divu
        logic              mdu_rd;   // mfhi/mflo
        logic [ALU_W-1:0]  alucontrol;
    } ctrl_t;

    // Unknown functs fall back to add.
    function automatic logic [ALU_W-1:0] rtype_alu(input logic [FUNCT_W-1:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational D-stage main decoder.
// Ports: op, funct (instruction fields) -> ctrl_c (decoded controls).
module mips_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output ctrl_t              ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (op)
            OP_RTYPE: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.regdst     = 1'b1;
                ctrl_c.alucontrol = rtype_alu(funct);
                ctrl_c.mdu_op     = (funct == FN_MULT) || (funct == FN_MULTU) ||
                                    (funct == FN_DIV)  || (funct == FN_DIVU);
                ctrl_c.mdu_rd     = (funct == FN_MFHI) || (funct == FN_MFLO);
            end
            OP_LW: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.alusrc     = 1'b1;
                ctrl_c.memtoreg   = 1'b1;
                ctrl_c.memen      = 1'b1;
                ctrl_c.alucontrol = ALU_ADD;
            end
            OP_SW: begin
                ctrl_c.memwrite   = 1'b1;
                ctrl_c.memen      = 1'b1;
                ctrl_c.alusrc     = 1'b1;
                ctrl_c.alucontrol = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_c.branch     = 1'b1;
                ctrl_c.alucontrol = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.alusrc     = 1'b1;
                ctrl_c.alucontrol = ALU_ADD;
            end
            OP_J: begin
                ctrl_c.jump       = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// MIPS 5-stage pipeline controller: D decode, E/M/W control pipeline,
// load-use and multiply/divide hazard detection, branch flush.
// Ports: clk, rst (sync, active-low); instr (D), zeroE, writeregE in;
// jumpD, E/M/W controls, stallF/stallD/flushD/flushE, mdu_busy out.
// MDU_LAT must lie in 1..15 to fit the 4-bit busy counter.
module mips_pipe_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned MDU_LAT   = 4,
    parameter int unsigned HAS_MDU   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 zeroE,
    input  logic [4:0]           writeregE,
    output logic                 jumpD,
    output logic                 pcsrcE,
    output logic                 alusrcE,
    output logic                 regdstE,
    output logic                 memtoregE,
    output logic                 regwriteE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 memwriteM,
    output logic                 memenM,
    output logic                 memtoregM,
    output logic                 regwriteM,
    output logic                 memtoregW,
    output logic                 regwriteW,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 mdu_busy
);

    ctrl_t dec;
    logic  branchE, memwriteE, memenE, mdu_e;
    logic  lu_haz, mdu_haz;
    logic  unused_bits;

    mips_decode u_decode (
        .op     (instr[31:26]),
        .funct  (instr[5:0]),
        .ctrl_c (dec)
    );

    assign unused_bits = ^instr[15:6];
    assign jumpD       = dec.jump;

    // D -> E; a flush or reset inserts a bubble.
    always_ff @(posedge clk) begin
        if (!rst || flushE) begin
            regwriteE   <= 1'b0;
            memtoregE   <= 1'b0;
            memwriteE   <= 1'b0;
            memenE      <= 1'b0;
            branchE     <= 1'b0;
            alusrcE     <= 1'b0;
            regdstE     <= 1'b0;
            alucontrolE <= '0;
            mdu_e       <= 1'b0;
        end else begin
            regwriteE   <= dec.regwrite;
            memtoregE   <= dec.memtoreg;
            memwriteE   <= dec.memwrite;
            memenE      <= dec.memen;
            branchE     <= dec.branch;
            alusrcE     <= dec.alusrc;
            regdstE     <= dec.regdst;
            alucontrolE <= ALUCTRL_W'(dec.alucontrol);
            mdu_e       <= dec.mdu_op;
        end
    end

    // E -> M -> W, never stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            memwriteM <= 1'b0;
            memenM    <= 1'b0;
            memtoregM <= 1'b0;
            regwriteM <= 1'b0;
            memtoregW <= 1'b0;
            regwriteW <= 1'b0;
        end else begin
            memwriteM <= memwriteE;
            memenM    <= memenE;
            memtoregM <= memtoregE;
            regwriteM <= regwriteE;
            memtoregW <= memtoregM;
            regwriteW <= regwriteM;
        end
    end

    // The counter loads once the MDU op sits in E, so the E cycle itself is
    // covered by mdu_e and the count covers the following MDU_LAT cycles.
    if (HAS_MDU != 0) begin : g_mdu
        logic [MDU_CNT_W-1:0] mdu_cnt;

        always_ff @(posedge clk) begin
            if (!rst) begin
                mdu_cnt <= '0;
            end else if (mdu_e) begin
                mdu_cnt <= MDU_CNT_W'(MDU_LAT);
            end else if (mdu_cnt != '0) begin
                mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
            end
        end

        assign mdu_busy = (mdu_cnt != '0);
        assign mdu_haz  = (dec.mdu_op || dec.mdu_rd) && (mdu_busy || mdu_e);
    end else begin : g_no_mdu
        logic unused_mdu;
        assign unused_mdu = dec.mdu_op ^ dec.mdu_rd ^ mdu_e;
        assign mdu_busy   = 1'b0;
        assign mdu_haz    = 1'b0;
    end

    assign lu_haz = memtoregE && (writeregE != 5'd0) &&
                    ((writeregE == instr[25:21]) || (writeregE == instr[20:16]));

    // A taken branch kills the D instruction, so it overrides any stall.
    assign pcsrcE = branchE && zeroE;
    assign flushD = pcsrcE;
    assign stallF = (lu_haz || mdu_haz) && !pcsrcE;
    assign stallD = stallF;
    assign flushE = lu_haz || mdu_haz || pcsrcE;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
module tb_mips_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zeroE;
    logic [4:0]  writeregE;

    logic       jumpD, pcsrcE, alusrcE, regdstE, memtoregE, regwriteE;
    logic [2:0] alucontrolE;
    logic       memwriteM, memenM, memtoregM, regwriteM, memtoregW, regwriteW;
    logic       stallF, stallD, flushD, flushE, mdu_busy;

    logic       jumpD_0, pcsrcE_0, alusrcE_0, regdstE_0, memtoregE_0, regwriteE_0;
    logic [2:0] alucontrolE_0;
    logic       memwriteM_0, memenM_0, memtoregM_0, regwriteM_0, memtoregW_0, regwriteW_0;
    logic       stallF_0, stallD_0, flushD_0, flushE_0, mdu_busy_0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_pipe_ctrl #(.ALUCTRL_W(3), .MDU_LAT(4), .HAS_MDU(1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zeroE(zeroE), .writeregE(writeregE),
        .jumpD(jumpD), .pcsrcE(pcsrcE), .alusrcE(alusrcE), .regdstE(regdstE),
        .memtoregE(memtoregE), .regwriteE(regwriteE), .alucontrolE(alucontrolE),
        .memwriteM(memwriteM), .memenM(memenM), .memtoregM(memtoregM),
        .regwriteM(regwriteM), .memtoregW(memtoregW), .regwriteW(regwriteW),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .mdu_busy(mdu_busy)
    );

    mips_pipe_ctrl #(.ALUCTRL_W(3), .MDU_LAT(4), .HAS_MDU(0)) dut0 (
        .clk(clk), .rst(rst), .instr(instr), .zeroE(zeroE), .writeregE(writeregE),
        .jumpD(jumpD_0), .pcsrcE(pcsrcE_0), .alusrcE(alusrcE_0), .regdstE(regdstE_0),
        .memtoregE(memtoregE_0), .regwriteE(regwriteE_0), .alucontrolE(alucontrolE_0),
        .memwriteM(memwriteM_0), .memenM(memenM_0), .memtoregM(memtoregM_0),
        .regwriteM(regwriteM_0), .memtoregW(memtoregW_0), .regwriteW(regwriteW_0),
        .stallF(stallF_0), .stallD(stallD_0), .flushD(flushD_0), .flushE(flushE_0),
        .mdu_busy(mdu_busy_0)
    );

    localparam logic [31:0] NOP = 32'hFC00_0000;  // opcode 0x3F

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] regs_all();
        return 32'({alusrcE, regdstE, memtoregE, regwriteE, alucontrolE,
                    memwriteM, memenM, memtoregM, regwriteM, memtoregW, regwriteW, mdu_busy});
    endfunction

    logic [5:0] fn_tab  [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    logic [2:0] alu_tab [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

    initial begin
        rst = 1'b0; instr = NOP; zeroE = 1'b0; writeregE = 5'd0;
        tick(); tick();
        check("reset_regs", regs_all(), 32'd0);
        check("reset_hazards", 32'({stallF, stallD, flushD, flushE, pcsrcE}), 32'd0);
        rst = 1'b1;

        // jump decode
        instr = {6'h02, 26'h0}; #1;
        check("jumpD", 32'(jumpD), 32'd1);
        tick();

        // load-use: lw $2 in E, add $3,$2,$4 in D
        instr = itype(6'h23, 5'd1, 5'd2, 16'd0);
        tick();
        check("lw_in_E_memtoreg", 32'(memtoregE), 32'd1);
        writeregE = 5'd2;
        instr = rtype(5'd2, 5'd4, 5'd3, 6'h20); #1;
        check("lu_stall", 32'({stallF, stallD, flushE}), 32'b111);
        tick();
        check("lu_bubble_E", 32'(regwriteE), 32'd0);
        check("lu_cleared", 32'({stallF, stallD, flushE}), 32'b000);
        check("lw_in_M", 32'({memtoregM, regwriteM, memenM}), 32'b111);
        tick();
        check("add_in_E", 32'({regwriteE, regdstE, alucontrolE}), 32'b11_010);
        check("lw_in_W", 32'({memtoregW, regwriteW}), 32'b11);
        writeregE = 5'd0;

        // R-type ALU codes
        for (int i = 0; i < 6; i++) begin
            instr = rtype(5'd1, 5'd2, 5'd3, fn_tab[i]);
            tick();
            check($sformatf("alu_fn_%0h", fn_tab[i]), 32'(alucontrolE), 32'(alu_tab[i]));
        end
        instr = itype(6'h08, 5'd1, 5'd2, 16'd5);
        tick();
        check("addi_E", 32'({regwriteE, alusrcE, regdstE, memtoregE, alucontrolE}), 32'b1100_010);
        instr = itype(6'h04, 5'd1, 5'd2, 16'd5);
        tick();
        check("beq_not_taken", 32'({alucontrolE, pcsrcE, flushD}), 32'b110_00);

        // taken branch beats an MDU stall
        instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        instr = itype(6'h04, 5'd1, 5'd2, 16'd5); #1;
        check("beq_D_no_stall", 32'(stallD), 32'd0);
        tick();
        instr = rtype(5'd0, 5'd0, 5'd5, 6'h12); zeroE = 1'b0; #1;
        check("mdu_stall_untaken", 32'({pcsrcE, stallD, flushE}), 32'b011);
        zeroE = 1'b1; #1;
        check("branch_priority", 32'({pcsrcE, flushD, flushE, stallD, stallF}), 32'b11100);
        tick();
        zeroE = 1'b0; instr = NOP;
        for (int i = 0; i < 5; i++) tick();
        check("mdu_drained", 32'(mdu_busy), 32'd0);

        // mult then mflo: 5 stall cycles
        instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        instr = rtype(5'd0, 5'd0, 5'd5, 6'h12); #1;
        check("nomdu_no_stall", 32'(stallD_0), 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("mflo_stall_%0d", i), 32'(stallD), 32'd1);
            if (i > 0) check($sformatf("mflo_busy_%0d", i), 32'(mdu_busy), 32'd1);
            tick();
        end
        check("mflo_release", 32'({stallD, mdu_busy}), 32'b00);
        check("nomdu_busy", 32'(mdu_busy_0), 32'd0);
        tick();
        check("mflo_in_E", 32'(regwriteE), 32'd1);

        // back-to-back mult/div
        instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        instr = rtype(5'd3, 5'd4, 5'd0, 6'h1A);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("div_stall_%0d", i), 32'(stallD), 32'd1);
            tick();
        end
        check("div_release", 32'({stallD, mdu_busy}), 32'b00);
        tick();
        instr = NOP; #1;
        check("div_in_E_cnt0", 32'(mdu_busy), 32'd0);
        tick();
        check("div_reload", 32'(mdu_busy), 32'd1);
        tick(); tick(); tick();
        check("div_cnt1", 32'(mdu_busy), 32'd1);
        tick();
        check("div_done", 32'(mdu_busy), 32'd0);

        // reset aborts an in-flight MDU count
        instr = rtype(5'd1, 5'd2, 5'd0, 6'h18);
        tick();
        instr = NOP;
        tick();
        check("mult_busy", 32'(mdu_busy), 32'd1);
        rst = 1'b0;
        tick();
        check("midrun_reset", regs_all(), 32'd0);
        rst = 1'b1;
        instr = itype(6'h2B, 5'd1, 5'd2, 16'd0);
        tick();
        instr = NOP;
        tick();
        check("sw_in_M", 32'({memwriteM, memenM, regwriteM, memtoregM}), 32'b1100);

        // undefined opcode gives all-zero controls
        instr = 32'hFFFF_FFFF; #1;
        check("undef_jump", 32'(jumpD), 32'd0);
        tick();
        check("undef_E", 32'({alusrcE, regdstE, memtoregE, regwriteE, alucontrolE}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_pipe_ctrl.md
MIPS_PIPE_CTRL -- requirements
Module: mips_pipe_ctrl

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3: width of the ALU control code.
REQ-002 SHALL have parameter MDU_LAT, default 4: multiply/divide busy cycles, legal range 1..15.
REQ-003 SHALL have parameter HAS_MDU, default 1: 0 removes the MDU tracker, so mdu_busy is 0 and no MDU stalls occur.
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- instr  in  32  D-stage instruction.
- zeroE  in  1  E-stage ALU zero flag.
- writeregE  in  5  E-stage destination register.
- jumpD  out  1  jump in D.
- pcsrcE  out  1  taken branch in E.
- alusrcE, regdstE, memtoregE, regwriteE  out  1 each  E-stage controls.
- alucontrolE  out  ALUCTRL_W  E-stage ALU code.
- memwriteM, memenM, memtoregM, regwriteM  out  1 each  M-stage controls.
- memtoregW, regwriteW  out  1 each  W-stage controls.
- stallF, stallD, flushD, flushE  out  1 each  hazard controls.
- mdu_busy  out  1  MDU operation in flight.

Function
REQ-005 SHALL decode instr combinationally in D:
- R-type (op 0x00): regwrite and regdst.
- lw (op 0x23): regwrite, alusrc, memtoreg, memen; ALU add.
- sw (op 0x2B): memwrite, memen, alusrc; ALU add.
- beq (op 0x04): branch; ALU sub.
- addi (op 0x08): regwrite, alusrc; ALU add.
- j (op 0x02): jump.
- Any other opcode: all controls 0.
REQ-006 SHALL set the R-type ALU code from funct: 0x20 add=010, 0x22 sub=110, 0x24 and=000, 0x25 or=001, 0x2A slt=111; any other funct=010. Codes are zero-extended to ALUCTRL_W.
REQ-007 SHALL register D controls into E each cycle. When flushE=1 or reset, the E register loads all zeros.
REQ-008 SHALL advance E->M and M->W every cycle, unconditionally.
REQ-009 SHALL drive pcsrcE = branchE AND zeroE, and flushD = pcsrcE.
REQ-010 SHALL flag a load-use hazard when memtoregE=1, writeregE!=0, and writeregE equals instr[25:21] or instr[20:16].
REQ-011 SHALL classify these funct codes as MDU instructions: 0x18, 0x19, 0x1A, 0x1B.
REQ-012 SHALL classify mfhi (0x10) and mflo (0x12) as MDU readers.
REQ-013 SHALL load the MDU counter with MDU_LAT when an MDU instruction enters E unflushed.
REQ-014 SHALL otherwise decrement a nonzero MDU counter by 1 per cycle; mdu_busy = (counter != 0).
REQ-015 SHALL flag an MDU hazard when D holds an MDU instruction or reader, and either mdu_busy=1 or E holds an MDU instruction.
REQ-016 SHALL drive stallF = stallD = (load-use OR MDU hazard) AND NOT pcsrcE.
REQ-017 SHALL drive flushE = load-use OR MDU hazard OR pcsrcE.
REQ-018 SHALL give a taken branch priority over a simultaneous stall: the flush occurs and no stall is asserted.
REQ-019 SHALL keep a stalled D instruction stable, so it re-evaluates hazards every cycle until they clear.

Reset
REQ-020 SHALL, when rst=0 at a clock edge, clear all E/M/W control registers and the MDU counter.
REQ-021 SHALL hold every registered output at 0 the cycle after reset; combinational outputs follow from these cleared registers.
REQ-022 SHALL have reset asserted mid-operation abort an in-flight MDU count, with mdu_busy=0 on the next cycle.

Structure
REQ-023 SHALL keep opcode, funct and ALU-code constants in a shared package, mips_pkg.
REQ-024 SHALL place the combinational decoder in sub-module mips_decode, instantiated once.

Verification
REQ-025 lw $2 in E (writeregE=2), D=add $3,$2,$4 -> stallF=stallD=flushE=1 for one cycle; the add reaches E one cycle later with regwriteE=1, alucontrolE=010.
REQ-026 beq in E with zeroE=1, simultaneous load-use in D -> pcsrcE=flushD=flushE=1, stallD=0.
REQ-027 mult enters E, MDU_LAT=4, then mflo in D -> stallD=1 for 5 cycles (mult in E, then busy 4 cycles); stallD=0 when the counter reaches 0.
REQ-028 Back-to-back mult/div -> the second stalls until mdu_busy=0, then the counter reloads to 4.
REQ-029 mult in flight, rst=0 for one cycle -> all outputs 0 and mdu_busy=0 next cycle; a following sw gives memwriteM=memenM=1 two cycles after D.
REQ-030 HAS_MDU=0 -> mult followed by mflo produces no stalls; undefined opcode 0x3F gives all-zero controls.
